// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared defaults, stage state type and width helper for dff_pipe.
package dff_pipe_pkg;
  parameter int DFF_PIPE_DEF_WIDTH = 8;
  parameter int DFF_PIPE_DEF_STAGES = 4;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_st_e;
  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one elastic register slot (data word plus EMPTY/FULL state).
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  stage_st_e st;
  assign valid = (st == ST_FULL);
  // An empty slot always accepts, which is what collapses bubbles under stall.
  assign ready = (st == ST_EMPTY) | dn_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_EMPTY;
      data <= RST_VAL;
    end else if (flush) begin
      st   <= ST_EMPTY;
      data <= RST_VAL;
    end else if (ready) begin
      st   <= up_valid ? ST_FULL : ST_EMPTY;
      data <= up_data;
    end
  end
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: STAGES-deep valid/ready register pipeline with bubble collapsing and flush.
// Define DFF_PIPE_OCC_EN to add the occupancy output and its consistency check.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DFF_PIPE_DEF_WIDTH,
  parameter int STAGES = DFF_PIPE_DEF_STAGES,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [occ_w(STAGES)-1:0]    occupancy
`endif
);
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0] d [STAGES];
  logic in_hs;
  assign in_hs = in_valid & in_ready;
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic rdy, dn, uv;
    logic [WIDTH-1:0] ud;
    if (i == STAGES - 1) begin : g_last
      assign dn = out_ready;
    end else begin : g_mid
      assign dn = g_stg[i+1].rdy;
    end
    // Stage 0 holds its word unless a new one is actually accepted.
    if (i == 0) begin : g_first
      assign uv = in_hs;
      assign ud = in_hs ? in_data : d[0];
    end else begin : g_next
      assign uv = v[i-1];
      assign ud = d[i-1];
    end
    dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .up_valid(uv),
      .up_data(ud),
      .dn_ready(dn),
      .ready(rdy),
      .valid(v[i]),
      .data(d[i])
    );
  end
  assign in_ready = g_stg[0].rdy & ~flush;
  assign out_valid = v[STAGES-1];
  assign out_data = d[STAGES-1];
`ifdef DFF_PIPE_OCC_EN
  localparam int OW = occ_w(STAGES);
  logic [OW-1:0] occ;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ <= '0;
    else if (flush) occ <= '0;
    else occ <= occ + OW'(in_hs) - OW'(out_valid & out_ready);
  end
  assign occupancy = occ;
  always_ff @(posedge clk) begin
    if (rst_n) assert (occ == OW'($countones(v)));
  end
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed and randomized checks of dff_pipe at STAGES=1, 4 and 7.
module tb_dff_pipe;
  import dff_pipe_pkg::*;
  localparam int W = 8;
  localparam int NW = 1000;
  logic clk = 1'b0;
  logic rst_n, flush;
  logic iv [3], ir [3], ov [3], ordy [3];
  logic [W-1:0] id [3], od [3];
  logic [W-1:0] mem [3][1024];
  int acc [3], del [3];
  logic stall [3];
  logic [W-1:0] pd [3];
  int checks = 0, failures = 0;
  bit done;
`ifdef DFF_PIPE_OCC_EN
  logic [occ_w(1)-1:0] occ0;
  logic [occ_w(4)-1:0] occ1;
  logic [occ_w(7)-1:0] occ2;
`endif
  always #5 clk = ~clk;
  dff_pipe #(.WIDTH(W), .STAGES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ0)
`endif
  );
  dff_pipe #(.WIDTH(W), .STAGES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ1)
`endif
  );
  dff_pipe #(.WIDTH(W), .STAGES(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2])
`ifdef DFF_PIPE_OCC_EN
    , .occupancy(occ2)
`endif
  );
  function automatic int st(input int k);
    return k == 0 ? 1 : (k == 1 ? 4 : 7);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      id[k] = '0;
      ordy[k] = 1'b1;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 32'(ov[k]), 32'd0);
      chk("rst_out_data", 32'(od[k]), 32'd0);
      chk("rst_in_ready", 32'(ir[k]), 32'd1);
    end
    #4 rst_n = 1'b1;
    for (int t = 0; t < 28; t++) begin
      cyc();
      iv[1] = (t < 20);
      id[1] = W'(t + 1);
      #1;
      chk("stream_in_ready", 32'(ir[1]), 32'd1);
      chk("stream_out_valid", 32'(ov[1]), 32'(t >= 4 && t < 24));
      if (t >= 4 && t < 24) chk("stream_out_data", 32'(od[1]), 32'(t - 3));
    end
    for (int t = 0; t < 6; t++) begin
      cyc();
      ordy[1] = 1'b0;
      iv[1] = 1'b1;
      id[1] = (t < 4) ? W'(8'hA0 + t) : 8'hA4;
      #1;
      chk("fill_in_ready", 32'(ir[1]), 32'(t < 4));
      if (t >= 4) begin
        chk("fill_out_valid", 32'(ov[1]), 32'd1);
        chk("fill_out_data", 32'(od[1]), 32'hA0);
`ifdef DFF_PIPE_OCC_EN
        chk("fill_occupancy", 32'(occ1), 32'd4);
`endif
      end
    end
    for (int t = 0; t < 6; t++) begin
      cyc();
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      #1;
      chk("drain_out_valid", 32'(ov[1]), 32'(t < 4));
      if (t < 4) chk("drain_out_data", 32'(od[1]), 32'(8'hA0 + t));
    end
    for (int t = 0; t < 8; t++) begin
      cyc();
      ordy[1] = 1'b0;
      iv[1] = (t == 0 || t == 3);
      id[1] = (t == 0) ? 8'h11 : 8'h22;
      #1;
    end
    chk("bubble_stall_valid", 32'(ov[1]), 32'd1);
    chk("bubble_stall_data", 32'(od[1]), 32'h11);
    chk("bubble_in_ready", 32'(ir[1]), 32'd1);
    for (int t = 0; t < 3; t++) begin
      cyc();
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      #1;
      chk("bubble_out_valid", 32'(ov[1]), 32'(t < 2));
      if (t < 2) chk("bubble_out_data", 32'(od[1]), (t == 0) ? 32'h11 : 32'h22);
    end
    for (int t = 0; t < 5; t++) begin
      cyc();
      ordy[1] = 1'b0;
      iv[1] = (t < 3);
      id[1] = W'(8'h31 + t);
      #1;
    end
    cyc();
    flush = 1'b1;
    iv[1] = 1'b1;
    id[1] = 8'h55;
    #1;
    chk("flush_in_ready", 32'(ir[1]), 32'd0);
    chk("flush_cycle_out_valid", 32'(ov[1]), 32'd1);
    cyc();
    flush = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("post_flush_out_valid", 32'(ov[1]), 32'd0);
    chk("post_flush_out_data", 32'(od[1]), 32'd0);
    chk("post_flush_in_ready", 32'(ir[1]), 32'd1);
`ifdef DFF_PIPE_OCC_EN
    chk("post_flush_occupancy", 32'(occ1), 32'd0);
`endif
    for (int t = 0; t < 8; t++) begin
      cyc();
      ordy[1] = 1'b1;
      #1;
      chk("flush_dropped", 32'(ov[1]), 32'd0);
    end
    for (int t = 0; t < 6; t++) begin
      cyc();
      iv[1] = 1'b1;
      id[1] = W'(8'h41 + t);
      #1;
    end
    chk("pre_areset_out_valid", 32'(ov[1]), 32'd1);
    chk("pre_areset_out_data", 32'(od[1]), 32'h42);
    #2;
    rst_n = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("areset_out_valid", 32'(ov[1]), 32'd0);
    chk("areset_out_data", 32'(od[1]), 32'd0);
    #2 rst_n = 1'b1;
    for (int t = 0; t < 7; t++) begin
      cyc();
      iv[1] = (t == 0);
      id[1] = 8'h7E;
      #1;
      chk("post_areset_out_valid", 32'(ov[1]), 32'(t == 4));
      if (t == 4) chk("post_areset_out_data", 32'(od[1]), 32'h7E);
    end
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0;
      del[k] = 0;
      stall[k] = 1'b0;
      pd[k] = '0;
    end
    done = 1'b0;
    for (int c = 0; c < 30000 && !done; c++) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        if (stall[k]) begin
          chk("rnd_stall_valid", 32'(ov[k]), 32'd1);
          chk("rnd_stall_data", 32'(od[k]), 32'(pd[k]));
        end
`ifdef DFF_PIPE_OCC_EN
        chk("rnd_occupancy", (k == 0) ? 32'(occ0) : (k == 1) ? 32'(occ1) : 32'(occ2), 32'(acc[k] - del[k]));
`endif
        iv[k] = (acc[k] < NW) ? 1'($urandom_range(0, 1)) : 1'b0;
        id[k] = W'($urandom);
        ordy[k] = 1'($urandom_range(0, 1));
      end
      #1;
      done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk("rnd_in_ready", 32'(ir[k]), 32'((acc[k] - del[k] < st(k)) || ordy[k]));
        if (ov[k] && ordy[k]) begin
          chk("rnd_out_data", 32'(od[k]), (del[k] < acc[k]) ? 32'(mem[k][del[k]]) : 32'hxxxx_xxxx);
          del[k]++;
        end
        if (iv[k] && ir[k]) begin
          mem[k][acc[k]] = id[k];
          acc[k]++;
        end
        stall[k] = ov[k] && !ordy[k];
        pd[k] = od[k];
        if (acc[k] < NW || del[k] < acc[k]) done = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk("rnd_accepted", 32'(acc[k]), 32'(NW));
      chk("rnd_delivered", 32'(del[k]), 32'(NW));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised elastic register pipeline; successor to the single-bit/single-stage dff.
- STAGES cascaded WIDTH-bit register stages, each with its own valid bit.
- valid/ready backpressure, bubble collapsing and synchronous flush.
- Sits between producer and consumer blocks wherever a timing cut with flow control is needed; driven through an interface in the same environment style as dff.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- STAGES, 4, number of register stages (>=1).
- RST_VAL, '0, reset/flush value of every data register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages.
- in_valid  input  1  producer has data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  $clog2(STAGES+1)  count of full stages; present only with DFF_PIPE_OCC_EN.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: all valid bits=0, all data regs=RST_VAL, out_valid=0, out_data=RST_VAL.
  - in_ready reflects the empty pipe (1) unless flush=1.
- Per-stage state: EMPTY (valid=0) / FULL (valid=1). Stage 0 is the input, stage STAGES-1 is the output.
- Ready chain (combinational):
  - rdy[STAGES-1] = ~v[STAGES-1] | out_ready.
  - rdy[i] = ~v[i] | rdy[i+1].
  - in_ready = rdy[0] & ~flush.
- Per-stage update, if rdy[i]:
  - stage 0 loads v<=in_valid&in_ready and data<=in_data when in_valid&in_ready; otherwise data holds.
  - stage i>0 loads v<=v[i-1] and data<=data[i-1].
  - if ~rdy[i], stage holds.
- Transfers: in-handshake = in_valid&in_ready; out-handshake = out_valid&out_ready.
- Latency: STAGES cycles from in-handshake to out_valid with no stall. Throughput: 1 word/cycle with out_ready held high.
- Bubbles collapse: an EMPTY stage accepts upstream data even while downstream is stalled.
- Full pipe (all v=1) with out_ready=0: in_ready=0 and all data holds stable.
- Full pipe with out_ready=1: simultaneous in-handshake and out-handshake; occupancy is unchanged.
- flush=1 (synchronous, highest priority after reset):
  - next edge clears all v to 0 and data to RST_VAL.
  - in_ready=0 during flush, and an in_valid during flush is dropped.
  - out_valid may still be 1 in the flush cycle; an out-handshake in that cycle is legal and counts.
- Reset mid-operation: all in-flight data is discarded immediately (async), no partial output.
- out_data must not change while out_valid=1 and out_ready=0.
- STAGES=1 degenerates to a single flow-controlled register.

Optional Feature:
- Macro DFF_PIPE_OCC_EN.
- Defined:
  - adds the occupancy port = popcount of stage valid bits, registered alongside them.
  - reset/flush value 0; range 0..STAGES.
  - increments on in-handshake only, decrements on out-handshake only, unchanged on both or neither.
  - an assertion checks occupancy==popcount(v).
- Undefined: port, counter and assertion are absent; all other behaviour is identical.

Decomposition:
- dff_pipe_pkg holds:
  - function occ_w(stages) returning $clog2(stages+1).
  - typedef enum {ST_EMPTY, ST_FULL} stage_st_e, used for debug and coverage.
  - parameter DFF_PIPE_DEF_WIDTH=8, DFF_PIPE_DEF_STAGES=4.
- One sub-module, dff_pipe_stage:
  - WIDTH-bit register plus valid bit.
  - inputs up_valid, up_data, dn_ready, flush; outputs ready, valid, data.
  - dff_pipe generate-instantiates STAGES copies.

Test Plan:
- WIDTH=8, STAGES=4, reset, then stream 0x01..0x14 with out_ready=1 -> first out_valid 4 cycles after the first handshake, then 20 consecutive words in order, in_ready constantly 1.
- Fill with 0xA0..0xA3 while out_ready=0 -> in_ready drops after 4 accepts, out_data=0xA0 stable, (OCC_EN) occupancy=4. Raise out_ready -> 0xA0..0xA3 drain one per cycle.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22, out_ready=0 -> both reach stages 3 and 2 adjacent. Release out_ready -> 0x11 then 0x22 on back-to-back cycles.
- Flush with 3 words in flight and in_valid=1 data 0x55 -> next cycle out_valid=0, all data=RST_VAL, 0x55 never emerges, in_ready=0 during the flush cycle.
- Assert rst_n=0 asynchronously mid-stream between clock edges -> out_valid falls without waiting for clk, out_data=RST_VAL. After release, a fresh 0x7E passes with latency 4.
- Random valid/ready (50% each), 1000 words, STAGES=1 and STAGES=7 -> scoreboard shows in-order, lossless, no duplicates, out_data stable under stall.
